// File: rtl/game_timer_if.sv
// Signal bundle between the game timer and its surroundings: raw button and
// game-state status in, elapsed-time count and pulses out.
interface game_timer_if #(
    parameter int unsigned TIME_W = 11
);
    logic              btn_raw;
    logic              playerDied;
    logic              menuScreen;
    logic              winScreen;
    logic [TIME_W-1:0] game_time;
    logic              tick;
    logic              userSel;

    modport master (
        output btn_raw, playerDied, menuScreen, winScreen,
        input  game_time, tick, userSel
    );

    modport slave (
        input  btn_raw, playerDied, menuScreen, winScreen,
        output game_time, tick, userSel
    );
endinterface

// File: rtl/game_timer.sv
// Game timer: prescaled, saturating game_time counter with clear/hold control
// from the sequencer and collision block, plus a synchronized, debounced
// single-pulse userSel from the raw push-button.
module game_timer #(
    parameter int unsigned TICK_DIV        = 2500000,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIME_W          = 11
) (
    input logic         clk,
    input logic         reset,
    game_timer_if.slave bus
);
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIME_W-1:0]  TIME_MAX   = '1;

    typedef enum logic [1:0] {
        MODE_CLEAR,
        MODE_HOLD,
        MODE_RUN
    } mode_t;

    mode_t             mode;
    logic [1:0]        sync_q;
    logic [1:0]        warm_q;
    logic              btn_s;
    logic              armed;
    logic [DB_W-1:0]   db_cnt;
    logic              stable;
    logic              stable_d;
    logic              user_sel_q;
    logic [PRESC_W-1:0] presc;
    logic [TIME_W-1:0] game_time_q;
    logic              tick_q;

    assign btn_s         = sync_q[1];
    assign bus.game_time = game_time_q;
    assign bus.tick      = tick_q;
    assign bus.userSel   = user_sel_q;

    // Timer mode decode: death and menu clear, win screen holds, else run.
    always_comb begin
        mode = MODE_RUN;
        if (bus.playerDied || bus.menuScreen) begin
            mode = MODE_CLEAR;
        end else if (bus.winScreen) begin
            mode = MODE_HOLD;
        end
    end

    // Two-flop synchronizer for the raw button; warm_q marks when btn_s
    // reflects a real sample rather than the reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.btn_raw};
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    // Debounce btn_s into stable and emit one userSel pulse per accepted press.
    // armed only sets once a genuine released level has been seen, so a button
    // held through reset cannot produce a pulse until it is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            db_cnt     <= '0;
            stable     <= 1'b0;
            stable_d   <= 1'b0;
            user_sel_q <= 1'b0;
        end else begin
            if (warm_q[1] && !btn_s) begin
                armed <= 1'b1;
            end
            if (btn_s != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            stable_d   <= stable;
            user_sel_q <= armed & stable & ~stable_d;
        end
    end

    // Prescaler and saturating game_time; tick marks each real increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            game_time_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            case (mode)
                MODE_CLEAR: begin
                    presc       <= '0;
                    game_time_q <= '0;
                    tick_q      <= 1'b0;
                end
                MODE_HOLD: begin
                    tick_q <= 1'b0;
                end
                default: begin
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                        if (game_time_q != TIME_MAX) begin
                            game_time_q <= game_time_q + 1'b1;
                            tick_q      <= 1'b1;
                        end else begin
                            tick_q <= 1'b0;
                        end
                    end else begin
                        presc  <= presc + 1'b1;
                        tick_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer with small parameters. A behavioural
// model tracks run cycles since the last clear and a sliding window of
// synchronized button samples; every clock the DUT outputs are compared.
module tb_game_timer;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned TIME_W   = 4;
    localparam int          MAXV     = (1 << TIME_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    game_timer_if #(.TIME_W(TIME_W)) bus ();

    game_timer #(
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .TIME_W(TIME_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    int rc;
    int edge_n;
    bit raw_q[$];
    bit bs_q[$];
    bit m_stable;
    bit prev_rise;
    bit low_seen;

    // observation counters
    int pulses;
    int last_pulse_edge;
    int ticks;
    int first_tick_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rc = 0;
        edge_n = 0;
        raw_q.delete();
        bs_q.delete();
        m_stable = 1'b0;
        prev_rise = 1'b0;
        low_seen = 1'b0;
    endtask

    task automatic step(input string tag);
        bit bs, valid, all_diff, rise, run, etick, eusel;
        int et;
        @(posedge clk);
        #1;
        edge_n++;

        run = !(bus.playerDied || bus.menuScreen) && !bus.winScreen;
        if (bus.playerDied || bus.menuScreen) rc = 0;
        else if (!bus.winScreen) rc++;
        et    = (rc / TICK_DIV > MAXV) ? MAXV : rc / TICK_DIV;
        etick = run && (rc % TICK_DIV == 0) && (rc / TICK_DIV <= MAXV);

        raw_q.push_back(bus.btn_raw);
        valid = (raw_q.size() >= 3);
        bs = valid ? raw_q[raw_q.size() - 3] : 1'b0;
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        eusel = prev_rise && low_seen;
        if (valid && !bs) low_seen = 1'b1;
        bs_q.push_back(bs);
        if (bs_q.size() > DEB) void'(bs_q.pop_front());
        all_diff = (bs_q.size() == DEB);
        foreach (bs_q[i]) if (bs_q[i] == m_stable) all_diff = 1'b0;
        rise = 1'b0;
        if (all_diff) begin
            m_stable = !m_stable;
            rise = m_stable;
        end
        prev_rise = rise;

        chk({tag, ".game_time"}, 32'(bus.game_time), et);
        chk({tag, ".tick"}, 32'(bus.tick), int'(etick));
        chk({tag, ".userSel"}, 32'(bus.userSel), int'(eusel));

        if (bus.userSel === 1'b1) begin
            pulses++;
            last_pulse_edge = edge_n;
        end
        if (bus.tick === 1'b1) begin
            ticks++;
            if (first_tick_edge < 0) first_tick_edge = edge_n;
        end
    endtask

    initial begin
        int e0;
        int btn_hold;

        reset = 1'b1;
        bus.btn_raw    = 1'b0;
        bus.playerDied = 1'b0;
        bus.menuScreen = 1'b1;
        bus.winScreen  = 1'b0;
        pulses = 0;
        ticks = 0;
        last_pulse_edge = -1000;
        first_tick_edge = -1;
        model_reset();

        #12;
        chk("reset.game_time", 32'(bus.game_time), 0);
        chk("reset.tick", 32'(bus.tick), 0);
        chk("reset.userSel", 32'(bus.userSel), 0);
        #1 reset = 1'b0;
        model_reset();

        repeat (5) step("idle");

        // short glitch must be rejected
        pulses = 0;
        bus.btn_raw = 1'b1;
        repeat (2) step("glitch");
        bus.btn_raw = 1'b0;
        repeat (10) step("glitch_low");
        chk("glitch_pulses", 32'(pulses), 0);

        // clean press, release, press again
        pulses = 0;
        last_pulse_edge = -1000;
        e0 = edge_n;
        bus.btn_raw = 1'b1;
        repeat (20) step("press1");
        chk("press1_pulses", 32'(pulses), 1);
        chk("press1_latency", 32'(last_pulse_edge - e0), 6);
        pulses = 0;
        bus.btn_raw = 1'b0;
        repeat (10) step("release1");
        last_pulse_edge = -1000;
        e0 = edge_n;
        bus.btn_raw = 1'b1;
        repeat (20) step("press2");
        chk("press2_pulses", 32'(pulses), 1);
        chk("press2_latency", 32'(last_pulse_edge - e0), 6);
        bus.btn_raw = 1'b0;
        repeat (8) step("release2");

        // run from clear for 40 cycles
        ticks = 0;
        first_tick_edge = -1;
        e0 = edge_n;
        bus.menuScreen = 1'b0;
        repeat (40) step("run");
        chk("run_time", 32'(bus.game_time), 10);
        chk("run_ticks", 32'(ticks), 10);
        chk("run_first_tick", 32'(first_tick_edge - e0), 4);

        // clear, run to 5, hold with button noise, resume
        bus.playerDied = 1'b1;
        step("die1");
        bus.playerDied = 1'b0;
        repeat (20) step("run5");
        chk("run5_time", 32'(bus.game_time), 5);
        bus.winScreen = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.btn_raw = 1'($urandom % 2);
            step("hold");
        end
        bus.btn_raw = 1'b0;
        chk("hold_time", 32'(bus.game_time), 5);
        bus.winScreen = 1'b0;
        repeat (8) step("resume");
        chk("resume_time", 32'(bus.game_time), 7);

        // single-cycle death, then first increment 4 cycles later
        bus.playerDied = 1'b1;
        step("die2");
        bus.playerDied = 1'b0;
        chk("die2_time", 32'(bus.game_time), 0);
        ticks = 0;
        first_tick_edge = -1;
        e0 = edge_n;
        repeat (4) step("post_die");
        chk("post_die_first_tick", 32'(first_tick_edge - e0), 4);

        // death coinciding with the last prescaler count: clear wins
        bus.menuScreen = 1'b1;
        step("clr");
        bus.menuScreen = 1'b0;
        repeat (3) step("pre_last");
        bus.playerDied = 1'b1;
        step("die_at_last");
        bus.playerDied = 1'b0;
        chk("die_at_last_tick", 32'(bus.tick), 0);
        chk("die_at_last_time", 32'(bus.game_time), 0);

        // saturation
        repeat (64) step("sat_run");
        chk("sat_time", 32'(bus.game_time), MAXV);
        ticks = 0;
        repeat (12) step("sat_hold");
        chk("sat_ticks", 32'(ticks), 0);
        chk("sat_hold_time", 32'(bus.game_time), MAXV);

        // reset mid-count with button held
        bus.menuScreen = 1'b1;
        step("clr2");
        bus.menuScreen = 1'b0;
        repeat (28) step("run7");
        chk("run7_time", 32'(bus.game_time), 7);
        bus.btn_raw = 1'b1;
        repeat (8) step("held");
        #2 reset = 1'b1;
        #1;
        chk("midreset.game_time", 32'(bus.game_time), 0);
        chk("midreset.tick", 32'(bus.tick), 0);
        chk("midreset.userSel", 32'(bus.userSel), 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        pulses = 0;
        repeat (20) step("post_reset_held");
        chk("post_reset_pulses", 32'(pulses), 0);
        bus.btn_raw = 1'b0;
        repeat (10) step("post_reset_release");
        pulses = 0;
        last_pulse_edge = -1000;
        e0 = edge_n;
        bus.btn_raw = 1'b1;
        repeat (15) step("post_reset_press");
        chk("post_reset_press_pulses", 32'(pulses), 1);
        chk("post_reset_press_latency", 32'(last_pulse_edge - e0), 6);

        // randomized soak against the model
        btn_hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (btn_hold == 0) begin
                bus.btn_raw = 1'($urandom % 2);
                btn_hold = int'($urandom_range(1, 8));
            end
            btn_hold--;
            bus.playerDied = ($urandom % 60 == 0);
            bus.menuScreen = ($urandom % 40 == 0);
            if ($urandom % 20 == 0) bus.winScreen = !bus.winScreen;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Sits directly upstream of the level sequencer.
- Produces the free-running game_time count that drives level advancement.
- Produces the debounced single-cycle userSel pulse from the raw push-button.
- Clears or holds the count from the sequencer's menuScreen/winScreen status and the collision block's playerDied flag.

Parameters:
- TICK_DIV, 2500000: clk cycles per game_time increment (25 MHz clk gives 10 ticks/s).
- DEBOUNCE_CYCLES, 250000: consecutive clk cycles the synchronized button must hold a new level before it is accepted.
- TIME_W, 11: width of game_time.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_raw  in  1  raw push-button, asynchronous to clk, active-high.
- playerDied  in  1  collision flag, synchronous, level.
- menuScreen  in  1  sequencer is in menu/menuDelay.
- winScreen  in  1  sequencer is in pWDelay/playerWins.
- game_time  out  TIME_W  elapsed ticks since play start.
- tick  out  1  one-cycle pulse in the cycle game_time increments.
- userSel  out  1  one-cycle pulse per accepted button press.

Behaviour:
- Reset clears everything: game_time=0, tick=0, userSel=0, prescaler=0, debounce counter=0, stable level=0, synchronizer flops=0.
- Button path, stage 1: 2-flop synchronizer on btn_raw gives btn_s (2-cycle latency).
- Button path, stage 2: debounce counter compares btn_s against the registered stable level.
  - If they differ, counter increments.
  - If they are equal, counter clears to 0.
  - When counter reaches DEBOUNCE_CYCLES-1 while still differing, stable level takes btn_s and counter clears.
- Button path, stage 3: userSel=1 for exactly one cycle, the cycle after stable goes 0->1.
  - Release (1->0) produces no pulse.
  - Holding the button produces exactly one pulse.
- Button path, stage 4: a glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse and resets the counter.
- The button path runs independently of all game-state inputs; it is not gated by menuScreen or winScreen.
- Timer mode, checked in priority order each clock:
  1. playerDied=1: clear. game_time=0 and prescaler=0 on next edge.
  2. menuScreen=1: clear, same as mode 1.
  3. winScreen=1: hold. game_time and prescaler keep their values.
  4. Otherwise: run.
- Run mode: prescaler counts 0..TICK_DIV-1 and wraps.
  - In the cycle prescaler==TICK_DIV-1, game_time increments on that edge and tick is registered high for the following cycle only.
  - The first increment after leaving clear occurs exactly TICK_DIV run cycles later.
- Saturation: game_time stops at 2^TIME_W-1 (2047).
  - At saturation, prescaler keeps wrapping but game_time does not change.
  - tick stays 0 at saturation (tick only asserts on an actual increment).
- tick is 0 in clear and hold modes.
- playerDied arriving with the prescaler at TICK_DIV-1: clear wins; no increment and no tick.
- The sequencer samples game_time thresholds (130, 260, ... 1300) each cycle; game_time never skips a value and never decreases except via clear.
- Reset asserted mid-count or mid-debounce: immediate return to reset values. No userSel pulse is emitted on reset deassertion, even with the button held. A pulse requires release, then a new debounced press.

Test Plan:
- Debounce glitch (TICK_DIV=4, DEBOUNCE_CYCLES=3): btn_raw high 2 cycles then low -> userSel never asserts.
- Clean press: btn_raw held high 20 cycles -> exactly one userSel pulse, 2 (sync) + 3 (debounce) + 1 (edge) cycles after the rising edge. Release and press again -> a second single pulse.
- Run: menuScreen=0, winScreen=0 for 40 cycles from clear -> game_time reaches 10, tick pulses every 4th cycle, first tick at cycle 4.
- Hold/clear: run to game_time=5, assert winScreen 12 cycles -> game_time stays 5. Drop winScreen -> counting resumes from 5. Pulse playerDied 1 cycle -> game_time=0 next cycle, next increment 4 cycles later.
- Saturation: preload by running to 2047 (or TIME_W=4, run to 15) -> game_time holds at max and tick stays 0 for 3 further prescaler wraps.
- Reset mid-operation: assert reset with game_time=7 and button held -> all outputs 0 immediately. Deassert reset with button still held -> no userSel until the button is released and pressed again.
